// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing
// and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_regWr,
    input  logic             id_memToReg,
    input  logic             id_memWr,
    input  logic             id_usesRt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [31:0]      id_rsData,
    input  logic [31:0]      id_rtData,
    input  logic [31:0]      id_imm,
    input  logic [2:0]       id_aluOp,
    input  logic             ex_flush,
    output logic             ex_valid,
    output logic             ex_regWr,
    output logic             ex_memToReg,
    output logic             ex_memWr,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_rsData,
    output logic [31:0]      ex_rtData,
    output logic [31:0]      ex_imm,
    output logic [2:0]       ex_aluOp,
    output logic             stall,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef struct packed {
        logic        valid;
        logic        reg_wr;
        logic        mem_to_reg;
        logic        mem_wr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [2:0]  alu_op;
    } ex_stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ex_stage_t        ex_d, ex_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic             hazard;
    logic             bubble;

    // A load in EX whose destination feeds the decoding instruction must wait
    // one cycle; $zero never carries a real dependency.
    assign hazard = id_valid & ex_q.valid & ex_q.mem_to_reg & (ex_q.rd != 5'd0) &
                    ((id_rs == ex_q.rd) | (id_usesRt & (id_rt == ex_q.rd)));

    // The flushed instruction is squashed anyway, so holding it would be wasted.
    assign stall  = hazard & ~ex_flush;
    assign bubble = ex_flush | hazard | ~id_valid;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        ex_d        = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!bubble) begin
            ex_d.valid      = 1'b1;
            ex_d.reg_wr     = id_regWr;
            ex_d.mem_to_reg = id_memToReg;
            ex_d.mem_wr     = id_memWr;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.rd         = id_rd;
            ex_d.rs_data    = id_rsData;
            ex_d.rt_data    = id_rtData;
            ex_d.imm        = id_imm;
            ex_d.alu_op     = id_aluOp;
        end

        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ex_flush && id_valid && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_regWr    = ex_q.reg_wr;
    assign ex_memToReg = ex_q.mem_to_reg;
    assign ex_memWr    = ex_q.mem_wr;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_rd       = ex_q.rd;
    assign ex_rsData   = ex_q.rs_data;
    assign ex_rtData   = ex_q.rt_data;
    assign ex_imm      = ex_q.imm;
    assign ex_aluOp    = ex_q.alu_op;
    assign stallCount  = stall_cnt_q;
    assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: capture, load-use stall,
// rt masking, $zero, flush priority, async reset and counter saturation.
module tb_id_ex_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid, id_regWr, id_memToReg, id_memWr, id_usesRt;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic [31:0]      id_rsData, id_rtData, id_imm;
    logic [2:0]       id_aluOp;
    logic             ex_flush;
    logic             ex_valid, ex_regWr, ex_memToReg, ex_memWr;
    logic [4:0]       ex_rs, ex_rt, ex_rd;
    logic [31:0]      ex_rsData, ex_rtData, ex_imm;
    logic [2:0]       ex_aluOp;
    logic             stall;
    logic [CNT_W-1:0] stallCount, flushCount;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_regWr(id_regWr), .id_memToReg(id_memToReg),
        .id_memWr(id_memWr), .id_usesRt(id_usesRt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rsData(id_rsData), .id_rtData(id_rtData), .id_imm(id_imm),
        .id_aluOp(id_aluOp), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_regWr(ex_regWr), .ex_memToReg(ex_memToReg),
        .ex_memWr(ex_memWr), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rsData(ex_rsData), .ex_rtData(ex_rtData), .ex_imm(ex_imm),
        .ex_aluOp(ex_aluOp), .stall(stall),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic load, input logic uses_rt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rs_data, input logic [31:0] rt_data,
                         input logic [2:0] alu_op);
        id_valid    = valid;
        id_regWr    = 1'b1;
        id_memToReg = load;
        id_memWr    = 1'b0;
        id_usesRt   = uses_rt;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_rsData   = rs_data;
        id_rtData   = rt_data;
        id_imm      = 32'h0000_0033;
        id_aluOp    = alu_op;
    endtask

    initial begin
        reset    = 1'b1;
        ex_flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 3'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_stallCount", 32'(stallCount), 0);
        check("rst_flushCount", 32'(flushCount), 0);
        reset = 1'b0;
        #1;

        // Basic capture
        drive(1'b1, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 3'd2);
        #1;
        check("cap_stall_before", 32'(stall), 0);
        tick();
        check("cap_ex_valid", 32'(ex_valid), 1);
        check("cap_ex_rs", 32'(ex_rs), 3);
        check("cap_ex_rt", 32'(ex_rt), 4);
        check("cap_ex_rd", 32'(ex_rd), 5);
        check("cap_ex_rsData", ex_rsData, 32'h11);
        check("cap_ex_rtData", ex_rtData, 32'h22);
        check("cap_ex_imm", ex_imm, 32'h33);
        check("cap_ex_aluOp", 32'(ex_aluOp), 2);
        check("cap_ex_regWr", 32'(ex_regWr), 1);
        check("cap_stall_after", 32'(stall), 0);

        // Load-use hazard on rs
        drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 3'd0);
        tick();
        check("lu_ex_memToReg", 32'(ex_memToReg), 1);
        drive(1'b1, 1'b0, 1'b1, 5'd8, 5'd9, 5'd10, 32'hAA, 32'hBB, 3'd3);
        #1;
        check("lu_stall", 32'(stall), 1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 0);
        check("lu_bubble_regWr", 32'(ex_regWr), 0);
        check("lu_bubble_rd", 32'(ex_rd), 0);
        check("lu_stall_cleared", 32'(stall), 0);
        check("lu_stallCount", 32'(stallCount), 1);
        tick();
        check("lu_issue_valid", 32'(ex_valid), 1);
        check("lu_issue_rs", 32'(ex_rs), 8);
        check("lu_issue_rsData", ex_rsData, 32'hAA);
        check("lu_stallCount_hold", 32'(stallCount), 1);

        // rt ignored when usesRt = 0
        drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 3'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd2, 5'd8, 5'd11, 32'h5, 32'h6, 3'd1);
        #1;
        check("rt_masked_stall", 32'(stall), 0);
        id_usesRt = 1'b1;
        #1;
        check("rt_used_stall", 32'(stall), 1);
        id_usesRt = 1'b0;
        tick();
        check("rt_masked_issue", 32'(ex_valid), 1);
        check("rt_masked_ex_rt", 32'(ex_rt), 8);
        check("rt_stallCount", 32'(stallCount), 1);

        // Load to $zero never stalls
        drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 3'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd12, 32'h7, 32'h8, 3'd4);
        #1;
        check("zero_stall", 32'(stall), 0);
        tick();
        check("zero_issue", 32'(ex_valid), 1);

        // Flush beats hazard
        drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 3'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd8, 5'd3, 5'd13, 32'h9, 32'hA, 3'd5);
        ex_flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 0);
        tick();
        ex_flush = 1'b0;
        check("flush_bubble", 32'(ex_valid), 0);
        check("flush_flushCount", 32'(flushCount), 1);
        check("flush_stallCount", 32'(stallCount), 1);

        // Flush with nothing valid in ID is not counted; invalid ID gives a bubble
        drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 3'd1);
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        check("flush_invalid_count", 32'(flushCount), 1);
        check("invalid_bubble_rsData", ex_rsData, 0);

        // Asynchronous reset between edges
        drive(1'b1, 1'b1, 1'b1, 5'd6, 5'd7, 5'd14, 32'hDEAD, 32'hBEEF, 3'd6);
        tick();
        check("ar_pre_valid", 32'(ex_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_ex_valid", 32'(ex_valid), 0);
        check("ar_ex_rsData", ex_rsData, 0);
        check("ar_ex_rd", 32'(ex_rd), 0);
        check("ar_stallCount", 32'(stallCount), 0);
        check("ar_flushCount", 32'(flushCount), 0);
        check("ar_stall", 32'(stall), 0);
        #2;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 5'd15, 5'd16, 5'd17, 32'h1234, 32'h5678, 3'd7);
        tick();
        check("ar_first_capture", 32'(ex_valid), 1);
        check("ar_first_rsData", ex_rsData, 32'h1234);

        // Saturation: a self-dependent load stalls on every other edge
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd8, 32'h0, 32'h0, 3'd0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        repeat (20) tick();
        check("sat_mid_count", 32'(stallCount), 10);
        repeat (10) tick();
        check("sat_full_count", 32'(stallCount), 15);
        repeat (8) tick();
        check("sat_hold_count", 32'(stallCount), 15);
        check("sat_flushCount", 32'(flushCount), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports id_valid, id_regWr, id_memToReg, id_memWr, id_usesRt  input  1 each  decode-stage valid flag and control bits; id_memToReg marks a load.
REQ-005 SHALL have ports id_rs, id_rt, id_rd  input  5 each  decode-stage source and destination register numbers.
REQ-006 SHALL have ports id_rsData, id_rtData, id_imm  input  32 each  register-file read data and sign-extended immediate.
REQ-007 SHALL have port id_aluOp  input  3  ALU operation code.
REQ-008 SHALL have port ex_flush  input  1  branch or jump taken in EX; squash the decode-stage instruction.
REQ-009 SHALL have registered outputs ex_valid, ex_regWr, ex_memToReg, ex_memWr (1 each), ex_rs, ex_rt, ex_rd (5 each), ex_rsData, ex_rtData, ex_imm (32 each) and ex_aluOp (3), mirroring the id_* inputs one stage later; ex_rs and ex_rt with their data are the targetReg/targetData pairs for the forwarding muxes.
REQ-010 SHALL have port stall  output  1  combinational; holds PC and IF/ID when high.
REQ-011 SHALL have ports stallCount, flushCount  output  CNT_W each  event counters.

Function
REQ-012 SHALL compute hazard = id_valid & ex_valid & ex_memToReg & (ex_rd != 0) & ((id_rs == ex_rd) | (id_usesRt & (id_rt == ex_rd))).
REQ-013 SHALL drive stall = hazard & ~ex_flush.
REQ-014 SHALL load a bubble on the next edge when ex_flush = 1, hazard = 1 or id_valid = 0; otherwise it SHALL capture all id_* fields, with ex_valid = 1.
REQ-015 A bubble SHALL set ex_valid, ex_regWr, ex_memToReg and ex_memWr to 0, and every register-number, data, immediate and aluOp field to 0.
REQ-016 Latency SHALL be exactly one cycle from the id_* inputs to the ex_* outputs; there is no combinational path from id_* to ex_*.
REQ-017 stall SHALL assert for exactly one cycle per load-use hazard, because the inserted bubble clears ex_memToReg; the held instruction then issues on the following edge.
REQ-018 When ex_flush and hazard are both high, flush SHALL win: stall = 0 and a bubble is loaded.
REQ-019 A load whose ex_rd = 0 SHALL never cause a stall.
REQ-020 When id_usesRt = 0, id_rt SHALL be ignored for hazard detection.
REQ-021 stallCount SHALL increment by 1 on each edge where stall = 1 and saturate at all-ones.
REQ-022 flushCount SHALL increment by 1 on each edge where ex_flush = 1 and id_valid = 1, and saturate at all-ones.
REQ-023 The counters SHALL not wrap.

Reset
REQ-024 While reset = 1, all ex_* outputs, stallCount and flushCount SHALL be 0, asynchronously, regardless of clk.
REQ-025 stall SHALL read 0 during reset, since ex_valid = 0.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight instruction; the first edge after deassertion SHALL capture the id_* inputs normally.

Verification
REQ-027 Basic capture: reset, then id_valid = 1, id_rs = 3, id_rt = 4, id_rd = 5, id_rsData = 0x11, id_rtData = 0x22, id_aluOp = 2, one edge -> ex_valid = 1, ex_rs = 3, ex_rsData = 0x11, ex_aluOp = 2, stall = 0 throughout.
REQ-028 Load-use on rs: EX holds a load with ex_rd = 8; ID presents id_rs = 8 -> stall = 1 for exactly one cycle; next edge gives ex_valid = 0 and ex_regWr = 0; the following edge captures the ID instruction; stallCount = 1.
REQ-029 Rt masking and $zero: load with ex_rd = 8, ID presents id_rt = 8 and id_usesRt = 0 -> stall = 0; load with ex_rd = 0 and id_rs = 0 -> stall = 0.
REQ-030 Flush priority: hazard condition present with ex_flush = 1 -> stall = 0; next edge ex_valid = 0; flushCount = 1, stallCount unchanged.
REQ-031 Saturation: drive 2^CNT_W + 3 stall events -> stallCount holds all-ones.
REQ-032 Async reset: assert reset mid-cycle with ex_valid = 1 -> all outputs are 0 before the next clk edge.
